// File: rtl/siso_frame_receiver.sv
// rtl/siso_frame_receiver.sv - framed serial word receiver with one-deep valid/ready output buffer
module siso_frame_receiver #(
    parameter int WIDTH      = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             sample_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_perr,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             perr_q, perr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_perr_q, data_perr_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             word_done;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        data_perr_d  = data_perr_q;
        data_valid_d = data_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        word_done    = 1'b0;

        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        if (sample_en) begin
            case (state_q)
                IDLE: begin
                    if (serial_in) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {shift_q[WIDTH-2:0], serial_in};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    perr_d  = (^shift_q) ^ serial_in ^ PARITY_ODD;
                    state_d = STOP;
                end
                STOP: begin
                    // A high stop bit is a framing error, never a fresh start bit
                    state_d = IDLE;
                    if (serial_in) begin
                        frame_err_d = 1'b1;
                    end else begin
                        word_done = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The buffer frees up in the same cycle it is drained, so a draining buffer can reload
        if (word_done) begin
            if (!data_valid_q || data_ready) begin
                data_out_d   = shift_q;
                data_perr_d  = perr_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            data_perr_q  <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            data_perr_q  <= data_perr_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_perr  = data_perr_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_siso_frame_receiver.sv
// tb/tb_siso_frame_receiver.sv - directed self-checking bench for siso_frame_receiver
module tb_siso_frame_receiver;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic       sample_en;
    logic [3:0] data_out;
    logic       data_perr;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;

    int checks;
    int errors;

    siso_frame_receiver #(
        .WIDTH      (4),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .sample_en  (sample_en),
        .data_out   (data_out),
        .data_perr  (data_perr),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of input, then land just after the rising edge that consumed it
    task automatic step(input logic sin, input logic sen);
        serial_in = sin;
        sample_en = sen;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] bits);
        for (int i = 6; i >= 0; i--) begin
            step(bits[i], 1'b1);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] d, input logic p,
                              input logic v, input logic fe, input logic ov);
        check({tag, "_data"}, 32'(data_out), 32'(d));
        check({tag, "_perr"}, 32'(data_perr), 32'(p));
        check({tag, "_valid"}, 32'(data_valid), 32'(v));
        check({tag, "_ferr"}, 32'(frame_err), 32'(fe));
        check({tag, "_ovr"}, 32'(overrun), 32'(ov));
    endtask

    initial begin
        logic [6:0] strobe_bits;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        serial_in  = 1'b0;
        sample_en  = 1'b1;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1);
        check_outs("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b1);

        // Frame 0xA, even parity bit 0
        send(7'b1101000);
        check_outs("t1", 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("t1_valid_drop", 32'(data_valid), 32'd0);

        // Same data, wrong parity bit
        send(7'b1101010);
        check_outs("t2", 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("t2_valid_drop", 32'(data_valid), 32'd0);

        // Stop bit high, then a clean 0x3 frame starting at cycle 8
        send(7'b1011011);
        check("t3_ferr", 32'(frame_err), 32'd1);
        check("t3_valid", 32'(data_valid), 32'd0);
        step(1'b0, 1'b1);
        check("t3_ferr_pulse", 32'(frame_err), 32'd0);
        send(7'b1001100);
        check_outs("t3b", 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Overrun: buffer full with 0xA, 0x5 arrives back-to-back
        data_ready = 1'b0;
        send(7'b1101000);
        check_outs("t4a", 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
        send(7'b1010100);
        check_outs("t4ovr", 4'hA, 1'b0, 1'b1, 1'b0, 1'b1);
        data_ready = 1'b1;
        step(1'b0, 1'b1);
        check("t4_valid_drop", 32'(data_valid), 32'd0);
        check("t4_ovr_pulse", 32'(overrun), 32'd0);

        // Strobe every third cycle; junk on the line between strobes must be ignored
        strobe_bits = 7'b1110000;
        for (int i = 6; i >= 0; i--) begin
            step(strobe_bits[i], 1'b1);
            if (i != 0) begin
                step(~strobe_bits[i], 1'b0);
                step(1'b1, 1'b0);
                check($sformatf("t5_hold_valid%0d", i), 32'(data_valid), 32'd0);
                check($sformatf("t5_hold_ferr%0d", i), 32'(frame_err), 32'd0);
            end
        end
        check_outs("t5", 4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Asynchronous reset mid-frame while a word is buffered
        data_ready = 1'b0;
        send(7'b1010100);
        check_outs("t6pre", 4'h5, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_outs("t6async", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        reset      = 1'b0;
        data_ready = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_outs("t6idle", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(7'b1101000);
        check_outs("t6", 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("t6_valid_drop", 32'(data_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
